// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe
//  Description : WIDTH-bit, DEPTH-stage register pipeline with per-stage
//                valid bits and valid/ready handshakes on both sides.
//                Empty stages are filled by upstream beats while the output
//                is stalled (bubble collapsing). Exposes an occupancy count.
//                Optional build macro DFF_PIPE_NEGEDGE_EN moves every
//                register to the falling edge of clk. Reset stays asynchronous
//                in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             di,
    output logic                         out_valid,
    input  logic                         out_ready,
    // Output data (last stage register). "do" is a reserved word.
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_CW = $clog2(DEPTH + 1);

    // Stage state: data and valid per stage, 0 = input side
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [DEPTH-1:0] r_v;
    logic [c_CW-1:0]  r_count;

    // Per-stage handshake terms
    logic [DEPTH-1:0] w_mv;      // stage k hands its beat onward this cycle
    logic [DEPTH-1:0] w_ok;      // stage k is able to take a beat this cycle
    logic [DEPTH-1:0] w_load;    // stage k takes a beat this cycle
    logic [WIDTH-1:0] w_src [DEPTH];
    logic             w_acc;
    logic             w_drain;

    // Move chain resolved from the output side back to the input; the
    // out_ready to in_ready path is deliberately combinational end to end.
    always_comb begin
        w_mv = '0;
        w_ok = '0;
        w_mv[DEPTH-1] = r_v[DEPTH-1] && out_ready;
        w_ok[DEPTH-1] = !r_v[DEPTH-1] || w_mv[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_mv[k] = r_v[k] && w_ok[k+1];
            w_ok[k] = !r_v[k] || w_mv[k];
        end
    end

    // Input handshake; held low during reset and during a flush cycle
    assign in_ready = rst_n && !clr && w_ok[0];
    assign w_acc    = in_valid && in_ready;
    assign w_drain  = w_mv[DEPTH-1];

    // Load source and strobe for every stage
    always_comb begin
        w_load    = '0;
        w_load[0] = w_acc;
        w_src[0]  = di;
        for (int k = 1; k < DEPTH; k++) begin
            w_load[k] = w_mv[k-1];
            w_src[k]  = r_d[k-1];
        end
    end

    // Stage registers, valid bits and occupancy counter; flush beats moves
`ifdef DFF_PIPE_NEGEDGE_EN
    always_ff @(negedge clk or negedge rst_n) begin
`else
    always_ff @(posedge clk or negedge rst_n) begin
`endif
        if (!rst_n) begin
            r_v     <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= INIT;
            end
        end else if (clr) begin
            // Data registers keep stale contents; only validity is dropped
            r_v     <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_d[k] <= w_src[k];
                    r_v[k] <= 1'b1;
                end else if (w_mv[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
            r_count <= r_count + c_CW'(w_acc) - c_CW'(w_drain);
        end
    end

    assign out_valid = r_v[DEPTH-1];
    assign dout      = r_d[DEPTH-1];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_pipe
//  Description : Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4). A queue of
//                beat positions models occupancy and output timing; accepted
//                beats are queued as expected output and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

    localparam int               WIDTH = 8;
    localparam int               DEPTH = 4;
    localparam logic [WIDTH-1:0] INIT  = '0;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             clr       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] di        = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] dout;
    logic [2:0]       count;
    logic             act_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: stage position of every beat inside, oldest first
    int               m_pos [$];
    // Scoreboard: data expected at the output, oldest first
    logic [WIDTH-1:0] exp_q [$];

    dff_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .di        (di),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .count     (count)
    );

    always #5 clk = ~clk;

`ifdef DFF_PIPE_NEGEDGE_EN
    assign act_clk = ~clk;
`else
    assign act_clk = clk;
`endif

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // The oldest beat is visible once it has reached the last stage
    function automatic logic m_out_valid();
        if (m_pos.size() == 0) return 1'b0;
        return m_pos[0] == DEPTH - 1;
    endfunction

    // Monitor: every beat the consumer takes must be the oldest expected one
    always @(negedge act_clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_empty: got dout=%0h expected no beat at %0t", dout, $time);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
        end
    end

    // One clock cycle: drive, compare against model, then advance the model
    task automatic step(input logic iv, input logic [WIDTH-1:0] d,
                        input logic ordy, input logic c, output logic acc);
        logic mir;
        logic mdrain;
        int   prev;
        int   np;
        in_valid  = iv;
        di        = d;
        out_ready = ordy;
        clr       = c;
        @(negedge act_clk);
        mir    = rst_n && !c && ((m_pos.size() < DEPTH) || ordy);
        mdrain = rst_n && m_out_valid() && ordy;
        check("count", count, m_pos.size());
        check("out_valid", out_valid, m_out_valid());
        check("in_ready", in_ready, mir);
        acc = iv && mir;
        if (acc) exp_q.push_back(d);
        @(posedge act_clk);
        #1;
        if (!rst_n || c) begin
            m_pos.delete();
            exp_q.delete();
        end else begin
            if (mdrain) void'(m_pos.pop_front());
            prev = DEPTH;
            for (int i = 0; i < m_pos.size(); i++) begin
                np = m_pos[i] + 1;
                if (np > prev - 1) np = prev - 1;
                m_pos[i] = np;
                prev     = np;
            end
            if (acc) m_pos.push_back(0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic             a;
        logic [WIDTH-1:0] nxt;
        logic             iv;
        logic             ordy;
        logic             c;

        // Reset state
        @(negedge act_clk);
        check("rst_dout", dout, INIT);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_in_ready", in_ready, 1'b0);
        step(1'b1, 8'h11, 1'b1, 1'b0, a);
        rst_n = 1'b1;

        // Single beat: visible exactly DEPTH cycles after acceptance
        step(1'b1, 8'hA5, 1'b1, 1'b0, a);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, a);

        // Streaming at full rate
        for (int v = 1; v <= 16; v++) step(1'b1, 8'(v), 1'b1, 1'b0, a);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, a);

        // Stall and fill, then accept and drain together
        nxt = 8'h20;
        repeat (6) begin
            step(1'b1, nxt, 1'b0, 1'b0, a);
            if (a) nxt++;
        end
        repeat (4) begin
            step(1'b1, nxt, 1'b1, 1'b0, a);
            if (a) nxt++;
        end
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, a);

        // Flush with a beat offered in the clr cycle
        step(1'b1, 8'h40, 1'b0, 1'b0, a);
        step(1'b1, 8'h41, 1'b0, 1'b0, a);
        step(1'b1, 8'h42, 1'b0, 1'b0, a);
        step(1'b1, 8'h4F, 1'b0, 1'b1, a);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, a);

        // Asynchronous reset between edges with three beats inside
        step(1'b1, 8'h60, 1'b0, 1'b0, a);
        step(1'b1, 8'h61, 1'b0, 1'b0, a);
        step(1'b1, 8'h62, 1'b0, 1'b0, a);
        check("pre_rst_count", count, 3'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_count", count, 3'd0);
        check("async_dout", dout, INIT);
        check("async_in_ready", in_ready, 1'b0);
        m_pos.delete();
        exp_q.delete();
        step(1'b1, 8'h77, 1'b1, 1'b0, a);
        rst_n = 1'b1;
        step(1'b1, 8'h78, 1'b1, 1'b0, a);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, a);

        // Randomized traffic with held data, stalls and occasional flushes
        nxt = 8'($urandom);
        repeat (400) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            c    = ($urandom_range(0, 29) == 0);
            step(iv, nxt, ordy, c, a);
            if (a) nxt = 8'($urandom);
        end
        repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0, a);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit behavioural D flip-flop.
- WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits and a valid/ready handshake on both sides.
- Bubble-collapsing: a stalled output lets upstream stages fill empty slots. Exposes an occupancy count.
- Used as a generic retiming/delay element between producer and consumer blocks.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- INIT, {WIDTH{1'b0}}, data register value after reset

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous flush: drops all pipeline contents
- in_valid  input  1  producer has a beat on di
- in_ready  output  1  pipeline accepts a beat this cycle
- di  input  WIDTH  input data
- out_valid  output  1  do holds a valid beat
- out_ready  input  1  consumer takes the beat this cycle
- do  output  WIDTH  output data (last stage register)
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

Behaviour:
- Decided interface: one clock, clk; reset rst_n is asynchronous and active-low.
- State per stage k (0 = input side, DEPTH-1 = output side): data register d[k] and valid bit v[k].
- Reset (rst_n low, asynchronous):
  - all v[k] = 0, all d[k] = INIT, count = 0
  - out_valid = 0, do = INIT
  - in_ready = 0 while rst_n is low
- Move rules:
  - mv[DEPTH-1] = v[DEPTH-1] && out_ready.
  - Stage k can load when !v[k] || mv[k].
  - Stage k<DEPTH-1 moves when v[k] && (stage k+1 can load).
  - in_ready = !clr && (!v[0] || mv[0]).
  - The path out_ready -> in_ready is combinational through all stages. This is intentional.
- Capture at each edge:
  - Stage k loads d[k-1] when stage k-1 moves; stage 0 loads di when in_valid && in_ready.
  - v[k] is set on load and cleared when stage k moves out with nothing loading in.
  - d[k] changes only on load; empty stages keep stale data.
- Latency:
  - A beat accepted in cycle T with an empty pipe gives out_valid=1, do=beat in cycle T+DEPTH.
  - Throughput is 1 beat/cycle while out_ready is held high.
- Output stability: once out_valid=1, do and out_valid hold until the cycle out_ready=1.
- Stall (out_valid && !out_ready):
  - The last stage holds.
  - Upstream valid stages advance into empty slots each cycle until all DEPTH stages are valid.
  - in_ready=0 only when full and not draining.
- Full and draining: when count==DEPTH and out_ready=1, in_ready=1. Accept and drain in the same cycle; count is unchanged.
- count: next = count + accept - drain (accept = in_valid && in_ready, drain = out_valid && out_ready). Never exceeds DEPTH and never underflows.
- clr:
  - Has priority over all moves.
  - Next edge: all v = 0, count = 0; d registers are unchanged.
  - in_ready=0 during clr, so an in_valid beat in a clr cycle is not accepted.
  - out_valid/do are unaffected until that edge; a drain in the clr cycle still counts as taken by the consumer.
- Reset mid-stream: all contents are lost immediately. The first legal accept is in the first cycle with rst_n high.
- DEPTH=1: single register with full-throughput handshake (in_ready = !v[0] || out_ready).

Optional Feature:
- Macro: DFF_PIPE_NEGEDGE_EN.
- Defined: all stage, valid and count registers capture on the falling edge of clk, preserving the negative-edge timing of the predecessor flip-flop. Asynchronous rst_n behaviour is identical.
- Not defined: all registers capture on the rising edge of clk.
- Handshake semantics and latency in cycles are identical in both builds.

Test Plan:
- Reset, then single beat (WIDTH=8, DEPTH=4): rst_n low -> do=8'h00, out_valid=0, count=0. Then di=8'hA5, in_valid for one cycle at T, out_ready=1 -> out_valid=1, do=8'hA5 at T+4 only; count goes 1,1,1,1,0.
- Streaming: beats 1..16 on consecutive cycles, out_ready=1 -> output 1..16 in order on 16 consecutive cycles, in_ready stays 1, count peaks at 4.
- Stall and fill: out_ready=0, push 6 beats -> first 4 accepted, in_ready=0 from the cycle count=4. Raise out_ready with in_valid held -> accept and drain in the same cycle, count stays 4, order preserved.
- Flush: 3 beats inside, assert clr with in_valid=1 -> next cycle count=0, out_valid=0; the clr-cycle beat does not appear at do.
- Async reset mid-stream: drop rst_n between edges with count=3 -> out_valid=0, count=0, do=INIT immediately, without waiting for a clk edge.
- Build with DFF_PIPE_NEGEDGE_EN defined: rerun the single-beat test -> data changes only on falling clk edges, out_valid at T+4 (falling-edge cycles).
